// File: rtl/agu_pkg.sv
// Shared types and constants for the AGU memory request path.
package agu_pkg;

  localparam int TAG_W = 6;

  // funct3[1:0] access sizes; 2'b11 is not a legal RV32 load/store size
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // One finished memory request as held in the request FIFO (79 bits)
  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       be;
    logic             we;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rd_tag;
    logic             misaligned;
  } agu_mem_req_t;

endpackage

// File: rtl/agu_addr_calc.sv
// Combinational effective-address, byte-enable, store-lane and alignment
// computation for one AGU entry. The rd_tag field is left zero; the caller
// fills it in.
module agu_addr_calc
  import agu_pkg::*;
(
  input  logic [31:0]  op1,
  input  logic [31:0]  op2,
  input  logic [31:0]  imm,
  input  logic [2:0]   funct3,
  input  logic         ls,
  output agu_mem_req_t req
);

  logic [31:0] addr;
  logic [1:0]  lane;
  logic [3:0]  lane_be;
  logic        misaligned;

  assign addr = op1 + imm;
  assign lane = addr[1:0];

  // Byte-lane mask and alignment check by access size
  always_comb begin
    lane_be    = 4'h0;
    misaligned = 1'b0;
    case (funct3[1:0])
      LS_BYTE: lane_be = 4'b0001 << lane;
      LS_HALF: begin
        lane_be    = 4'b0011 << {lane[1], 1'b0};
        misaligned = lane[0];
      end
      LS_WORD: begin
        lane_be    = 4'hF;
        misaligned = (lane != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Assemble the request; misaligned accesses carry no lanes so the LSU
  // never touches memory for them, but the entry still flows in order.
  always_comb begin
    req            = '0;
    req.addr       = addr;
    req.wdata      = ls ? (op2 << {lane, 3'b000}) : 32'h0;
    req.be         = misaligned ? 4'h0 : lane_be;
    req.we         = ls;
    req.funct3     = funct3;
    req.misaligned = misaligned;
  end

endmodule

// File: rtl/agu_mem_req_buffer.sv
// In-order request FIFO between the AGU issue port and the load/store unit.
// Each accepted entry is converted to a memory request on the way in, so the
// FIFO head drives mem_* directly with no bypass from issue_*.
module agu_mem_req_buffer
  import agu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_op1_data,
  input  logic [31:0]      issue_op2_data,
  input  logic [TAG_W-1:0] issue_rd_tag,
  input  logic [2:0]       issue_funct3,
  input  logic             issue_agu_ls,
  input  logic [31:0]      issue_agu_imm,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             mem_we,
  output logic [2:0]       mem_funct3,
  output logic [TAG_W-1:0] mem_rd_tag,
  output logic             mem_misaligned,
  output logic [PTR_W:0]   buf_count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  agu_mem_req_t     calc_req;
  agu_mem_req_t     push_entry;
  agu_mem_req_t     head_entry;
  agu_mem_req_t     storage [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             clear;
  logic             push;
  logic             pop;

  agu_addr_calc u_addr_calc (
    .op1    (issue_op1_data),
    .op2    (issue_op2_data),
    .imm    (issue_agu_imm),
    .funct3 (issue_funct3),
    .ls     (issue_agu_ls),
    .req    (calc_req)
  );

  // Attach the destination tag to the computed request
  always_comb begin
    push_entry        = calc_req;
    push_entry.rd_tag = issue_rd_tag;
  end

  // A full FIFO can still take an entry when the head leaves in the same cycle
  assign clear         = rst | flush;
  assign mem_req_valid = (count_reg != '0);
  assign issue_ready   = (count_reg != FULL_COUNT) | mem_req_ready;
  assign push          = issue_valid & issue_ready & ~clear;
  assign pop           = mem_req_valid & mem_req_ready & ~clear;
  assign buf_count     = count_reg;

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr_reg] <= push_entry;
  end

  // Head request; zero while empty so stale entries never show on the bus
  assign head_entry     = mem_req_valid ? storage[rd_ptr_reg] : '0;
  assign mem_addr       = head_entry.addr;
  assign mem_wdata      = head_entry.wdata;
  assign mem_be         = head_entry.be;
  assign mem_we         = head_entry.we;
  assign mem_funct3     = head_entry.funct3;
  assign mem_rd_tag     = head_entry.rd_tag;
  assign mem_misaligned = head_entry.misaligned;

endmodule

// File: tb/tb_agu_mem_req_buffer.sv
// Scoreboard bench for agu_mem_req_buffer: stimulus pushes hand-computed
// expected requests, a negedge monitor pops and compares on every handshake.
module tb_agu_mem_req_buffer;
  import agu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_agu_ls, mem_req_ready;
  logic        issue_ready, mem_req_valid, mem_we, mem_misaligned;
  logic [31:0] issue_op1_data, issue_op2_data, issue_agu_imm;
  logic [31:0] mem_addr, mem_wdata;
  logic [5:0]  issue_rd_tag, mem_rd_tag;
  logic [2:0]  issue_funct3, mem_funct3;
  logic [3:0]  mem_be;
  logic [2:0]  buf_count;

  int errors = 0;
  int checks = 0;
  agu_mem_req_t exp_q[$];

  always #5 clk = ~clk;

  agu_mem_req_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op1_data(issue_op1_data), .issue_op2_data(issue_op2_data),
    .issue_rd_tag(issue_rd_tag), .issue_funct3(issue_funct3),
    .issue_agu_ls(issue_agu_ls), .issue_agu_imm(issue_agu_imm),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_rd_tag(mem_rd_tag),
    .mem_misaligned(mem_misaligned), .buf_count(buf_count)
  );

  function automatic agu_mem_req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] be, input logic we,
                                      input logic [2:0] f3, input logic [5:0] tag,
                                      input logic mis);
    agu_mem_req_t r;
    r.addr = addr; r.wdata = wdata; r.be = be; r.we = we;
    r.funct3 = f3; r.rd_tag = tag; r.misaligned = mis;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  // Offer one entry and wait (bounded) for acceptance; record its expected request
  task automatic issue(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                       input logic [2:0] f3, input logic ls, input logic [5:0] tag,
                       input agu_mem_req_t exp);
    int n = 0;
    issue_valid = 1'b1; issue_op1_data = op1; issue_op2_data = op2;
    issue_agu_imm = imm; issue_funct3 = f3; issue_agu_ls = ls; issue_rd_tag = tag;
    @(negedge clk);
    while (!issue_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!issue_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout tag=%0d: issue_ready=0 expected 1 within 50 cycles", tag);
    end else begin
      exp_q.push_back(exp);
      $display("push tag=%0d addr=0x%0h", tag, exp.addr);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  // Monitor: one comparison per consumed request
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && mem_req_valid && mem_req_ready) begin
      agu_mem_req_t act;
      agu_mem_req_t exp;
      act = mk(mem_addr, mem_wdata, mem_be, mem_we, mem_funct3, mem_rd_tag, mem_misaligned);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got tag=%0d addr=0x%0h expected no request", mem_rd_tag, mem_addr);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL pop tag=%0d: got %h expected %h", exp.rd_tag, act, exp);
        end else
          $display("pop  tag=%0d addr=0x%0h be=%b wdata=0x%0h mis=%0b ok",
                   act.rd_tag, act.addr, act.be, act.wdata, act.misaligned);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; mem_req_ready = 1'b0;
    issue_op1_data = '0; issue_op2_data = '0; issue_agu_imm = '0;
    issue_funct3 = '0; issue_agu_ls = 1'b0; issue_rd_tag = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_req_ready = 1'b1;

    // Load word, with latency checks around the accepting edge
    issue_valid = 1'b1; issue_op1_data = 32'h1000; issue_agu_imm = 32'h8;
    issue_funct3 = 3'b010; issue_agu_ls = 1'b0; issue_rd_tag = 6'd5;
    @(negedge clk);
    check("no_bypass_valid", 32'(mem_req_valid), 32'd0);
    exp_q.push_back(mk(32'h1008, 32'h0, 4'hF, 1'b0, 3'b010, 6'd5, 1'b0));
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    check("lw_valid_next", 32'(mem_req_valid), 32'd1);
    check("lw_count", 32'(buf_count), 32'd1);
    @(posedge clk); #1;

    // Store byte into lane 3
    issue(32'h2001, 32'hAB, 32'h2, 3'b000, 1'b1, 6'd6,
          mk(32'h2003, 32'hAB000000, 4'b1000, 1'b1, 3'b000, 6'd6, 1'b0));
    // Misaligned half-word load
    issue(32'h3001, 32'h0, 32'h0, 3'b001, 1'b0, 6'd7,
          mk(32'h3001, 32'h0, 4'h0, 1'b0, 3'b001, 6'd7, 1'b1));
    repeat (3) @(posedge clk); #1;

    // Back-pressure: fill all four entries
    mem_req_ready = 1'b0;
    issue(32'h100, 32'h1234, 32'h2, 3'b001, 1'b1, 6'd10,
          mk(32'h102, 32'h12340000, 4'b1100, 1'b1, 3'b001, 6'd10, 1'b0));
    issue(32'h200, 32'h0, 32'h1, 3'b100, 1'b0, 6'd11,
          mk(32'h201, 32'h0, 4'b0010, 1'b0, 3'b100, 6'd11, 1'b0));
    issue(32'h300, 32'hDEADBEEF, 32'hFFFFFFFC, 3'b010, 1'b1, 6'd12,
          mk(32'h2FC, 32'hDEADBEEF, 4'hF, 1'b1, 3'b010, 6'd12, 1'b0));
    issue(32'h400, 32'h55, 32'h0, 3'b011, 1'b1, 6'd13,
          mk(32'h400, 32'h55, 4'h0, 1'b1, 3'b011, 6'd13, 1'b1));
    @(negedge clk);
    check("full_ready", 32'(issue_ready), 32'd0);
    check("full_count", 32'(buf_count), 32'd4);
    check("full_valid", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;

    // Push and pop in the same cycle on a full FIFO
    mem_req_ready = 1'b1;
    issue(32'h500, 32'h0, 32'h2, 3'b010, 1'b0, 6'd14,
          mk(32'h502, 32'h0, 4'h0, 1'b0, 3'b010, 6'd14, 1'b1));
    @(negedge clk);
    check("pushpop_count", 32'(buf_count), 32'd4);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("drain_count", 32'(buf_count), 32'd0);
    @(posedge clk); #1;

    // Flush with three entries buffered and a push offered
    mem_req_ready = 1'b0;
    issue(32'h600, 32'h0, 32'h0, 3'b010, 1'b0, 6'd20,
          mk(32'h600, 32'h0, 4'hF, 1'b0, 3'b010, 6'd20, 1'b0));
    issue(32'h700, 32'h0, 32'h3, 3'b000, 1'b0, 6'd21,
          mk(32'h703, 32'h0, 4'b1000, 1'b0, 3'b000, 6'd21, 1'b0));
    issue(32'h800, 32'h0, 32'h2, 3'b101, 1'b0, 6'd22,
          mk(32'h802, 32'h0, 4'b1100, 1'b0, 3'b101, 6'd22, 1'b0));
    @(negedge clk);
    check("preflush_count", 32'(buf_count), 32'd3);
    @(posedge clk); #1;
    flush = 1'b1; issue_valid = 1'b1; issue_op1_data = 32'h900;
    issue_agu_imm = 32'h0; issue_funct3 = 3'b010; issue_rd_tag = 6'd23;
    @(negedge clk);
    check("flush_ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_count", 32'(buf_count), 32'd0);
    check("flush_valid", 32'(mem_req_valid), 32'd0);
    mem_req_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Address wraps modulo 2^32
    issue(32'hFFFFFFFC, 32'h0, 32'h8, 3'b010, 1'b0, 6'd30,
          mk(32'h4, 32'h0, 4'hF, 1'b0, 3'b010, 6'd30, 1'b0));
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("final_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("final_count", 32'(buf_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
